bp_commit: RTL and testbench

Commit-side companion to the branch predictor. Sits between the ROB head and the predictor/fetcher: takes one committed instruction per cycle, turns resolved branches into registered predictor update pulses (valid, jump, tag), detects mispredictions and runs a flush/recovery sequence. While recovering it stalls further commits.

---
 rtl/bp_commit.sv | 140 ++++++++++++++
 tb/tb_bp_commit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_commit.sv
// Commit-side branch predictor companion: turns committed branches into predictor
// updates and sequences flush/recovery on mispredicts. Optional stats: BP_COMMIT_STAT_EN.
module bp_commit #(
    parameter int TAG_W          = 8,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_commit_valid,
    input  logic             in_commit_is_branch,
    input  logic [31:0]      in_commit_pc,
    input  logic             in_commit_jump,
    input  logic             in_commit_pred,
    input  logic [31:0]      in_commit_target,
    output logic             out_commit_ready,
    output logic             out_bp_valid,
    output logic             out_bp_jump,
    output logic [TAG_W-1:0] out_bp_tag,
    output logic             out_flush,
`ifdef BP_COMMIT_STAT_EN
    output logic [31:0]      out_stat_branches,
    output logic [31:0]      out_stat_mispred,
`endif
    output logic [31:0]      out_flush_pc
);
    // state   | meaning
    // RUN     | accepting commits
    // FLUSH   | one-cycle flush pulse, recovery counter loaded
    // RECOVER | stalling commits until counter reaches 0
    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_RECOVER} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               bp_valid_q, bp_valid_d;
    logic               bp_jump_q, bp_jump_d;
    logic [TAG_W-1:0]   bp_tag_q, bp_tag_d;
    logic               flush_q, flush_d;
    logic [31:0]        flush_pc_q, flush_pc_d;
    logic               acc, br_acc, mispred;

    assign acc     = in_commit_valid & out_commit_ready & rdy;
    assign br_acc  = acc & in_commit_is_branch;
    assign mispred = br_acc & (in_commit_jump != in_commit_pred);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            bp_valid_q <= 1'b0;
            bp_jump_q  <= 1'b0;
            bp_tag_q   <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bp_valid_q <= bp_valid_d;
            bp_jump_q  <= bp_jump_d;
            bp_tag_q   <= bp_tag_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rdy) begin
            case (state_q)
                S_RUN: if (mispred) state_d = S_FLUSH;
                S_FLUSH: begin
                    state_d = S_RECOVER;
                    cnt_d   = 4'(RECOVER_CYCLES - 1);
                end
                S_RECOVER: begin
                    if (cnt_q == 4'd0) state_d = S_RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Registered outputs hold while rdy is low, so pulses stretch.
    always_comb begin
        bp_valid_d = bp_valid_q;
        bp_jump_d  = bp_jump_q;
        bp_tag_d   = bp_tag_q;
        flush_d    = flush_q;
        flush_pc_d = flush_pc_q;
        if (rdy) begin
            bp_valid_d = br_acc;
            flush_d    = mispred;
            if (br_acc) begin
                bp_jump_d = in_commit_jump;
                bp_tag_d  = in_commit_pc[TAG_W+1:2];
            end
            if (mispred)
                flush_pc_d = in_commit_jump ? in_commit_target : in_commit_pc + 32'd4;
        end
    end

    always_comb begin
        out_commit_ready = (state_q == S_RUN);
        out_bp_valid     = bp_valid_q;
        out_bp_jump      = bp_jump_q;
        out_bp_tag       = bp_tag_q;
        out_flush        = flush_q;
        out_flush_pc     = flush_pc_q;
    end

`ifdef BP_COMMIT_STAT_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    // Saturating counters; acc already includes rdy.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (br_acc && stat_branches_q != 32'hFFFF_FFFF)
            stat_branches_d = stat_branches_q + 32'd1;
        if (mispred && stat_mispred_q != 32'hFFFF_FFFF)
            stat_mispred_d = stat_mispred_q + 32'd1;
    end

    assign out_stat_branches = stat_branches_q;
    assign out_stat_mispred  = stat_mispred_q;
`endif
endmodule

// File: tb/tb_bp_commit.sv
// Directed self-checking bench for bp_commit (RECOVER_CYCLES = 2, TAG_W = 8).
module tb_bp_commit;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_commit_valid, in_commit_is_branch, in_commit_jump, in_commit_pred;
    logic [31:0] in_commit_pc, in_commit_target;
    logic        out_commit_ready, out_bp_valid, out_bp_jump, out_flush;
    logic [7:0]  out_bp_tag;
    logic [31:0] out_flush_pc;
`ifdef BP_COMMIT_STAT_EN
    logic [31:0] out_stat_branches, out_stat_mispred;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bp_commit #(.TAG_W(8), .RECOVER_CYCLES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_commit_valid     (in_commit_valid),
        .in_commit_is_branch (in_commit_is_branch),
        .in_commit_pc        (in_commit_pc),
        .in_commit_jump      (in_commit_jump),
        .in_commit_pred      (in_commit_pred),
        .in_commit_target    (in_commit_target),
        .out_commit_ready    (out_commit_ready),
        .out_bp_valid        (out_bp_valid),
        .out_bp_jump         (out_bp_jump),
        .out_bp_tag          (out_bp_tag),
        .out_flush           (out_flush),
`ifdef BP_COMMIT_STAT_EN
        .out_stat_branches   (out_stat_branches),
        .out_stat_mispred    (out_stat_mispred),
`endif
        .out_flush_pc        (out_flush_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                         input logic j, input logic p, input logic [31:0] tgt);
        in_commit_valid     = v;
        in_commit_is_branch = br;
        in_commit_pc        = pc;
        in_commit_jump      = j;
        in_commit_pred      = p;
        in_commit_target    = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!out_commit_ready && n < 20) begin
            step();
            n++;
        end
        check("wait_ready", {31'd0, out_commit_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        check("rst_ready", {31'd0, out_commit_ready}, 32'd1);
        check("rst_bp_valid", {31'd0, out_bp_valid}, 32'd0);
        check("rst_flush", {31'd0, out_flush}, 32'd0);
        check("rst_flush_pc", out_flush_pc, 32'd0);
        check("rst_tag", {24'd0, out_bp_tag}, 32'd0);
        step();
        check("idle_ready", {31'd0, out_commit_ready}, 32'd1);
        check("idle_bp_valid", {31'd0, out_bp_valid}, 32'd0);

        // correctly predicted taken branch
        drive(1'b1, 1'b1, 32'h0000_1010, 1'b1, 1'b1, 32'h0000_5000);
        step();
        idle();
        check("tk_valid", {31'd0, out_bp_valid}, 32'd1);
        check("tk_jump", {31'd0, out_bp_jump}, 32'd1);
        check("tk_tag", {24'd0, out_bp_tag}, 32'h04);
        check("tk_flush", {31'd0, out_flush}, 32'd0);
        check("tk_ready", {31'd0, out_commit_ready}, 32'd1);
        step();
        check("tk_valid_drop", {31'd0, out_bp_valid}, 32'd0);

        // not-taken mispredict; keep offering a mispredicting branch during stall
        drive(1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_9000);
        step();
        check("nt_flush", {31'd0, out_flush}, 32'd1);
        check("nt_flush_pc", out_flush_pc, 32'h0000_2004);
        check("nt_bp_valid", {31'd0, out_bp_valid}, 32'd1);
        check("nt_bp_jump", {31'd0, out_bp_jump}, 32'd0);
        check("nt_ready0", {31'd0, out_commit_ready}, 32'd0);
        step();
        check("nt_flush_off", {31'd0, out_flush}, 32'd0);
        check("nt_stall_bpv", {31'd0, out_bp_valid}, 32'd0);
        check("nt_ready1", {31'd0, out_commit_ready}, 32'd0);
        step();
        check("nt_ready2", {31'd0, out_commit_ready}, 32'd0);
        check("nt_stall_flush", {31'd0, out_flush}, 32'd0);
        step();
        check("nt_ready3", {31'd0, out_commit_ready}, 32'd1);
        idle();

        // taken mispredict at top of address space
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0100);
        step();
        idle();
        check("tmp_flush_pc", out_flush_pc, 32'h0000_0100);
        check("tmp_tag", {24'd0, out_bp_tag}, 32'h0000_00FF);
        wait_ready();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0100);
        step();
        idle();
        check("wrap_flush", {31'd0, out_flush}, 32'd1);
        check("wrap_flush_pc", out_flush_pc, 32'h0000_0000);
        wait_ready();

        // non-branch commits every cycle, with outcome/prediction disagreeing
        drive(1'b1, 1'b0, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_7000);
        for (int i = 0; i < 10; i++) begin
            step();
            in_commit_pc = in_commit_pc + 32'd4;
            check("nb_bp_valid", {31'd0, out_bp_valid}, 32'd0);
            check("nb_flush", {31'd0, out_flush}, 32'd0);
            check("nb_ready", {31'd0, out_commit_ready}, 32'd1);
        end
        idle();

        // back-to-back correct branches
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0000_0010 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
            step();
            check("b2b_valid", {31'd0, out_bp_valid}, 32'd1);
            check("b2b_tag", {24'd0, out_bp_tag}, 32'h4 + 32'(i));
            check("b2b_ready", {31'd0, out_commit_ready}, 32'd1);
        end
        idle();
        step();

        // rdy low during RECOVER freezes the counter
        drive(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_4000);
        step();
        idle();
        check("frz_flush", {31'd0, out_flush}, 32'd1);
        check("frz_flush_pc", out_flush_pc, 32'h0000_4000);
        step();
        check("frz_rec_ready", {31'd0, out_commit_ready}, 32'd0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_hold_ready", {31'd0, out_commit_ready}, 32'd0);
        end
        rdy = 1'b1;
        step();
        check("frz_last_ready", {31'd0, out_commit_ready}, 32'd0);
        step();
        check("frz_back_ready", {31'd0, out_commit_ready}, 32'd1);

        // rdy low right after a mispredict stretches the flush pulse
        drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h0);
        step();
        idle();
        rdy = 1'b0;
        step();
        step();
        check("str_flush", {31'd0, out_flush}, 32'd1);
        check("str_bp_valid", {31'd0, out_bp_valid}, 32'd1);
        check("str_flush_pc", out_flush_pc, 32'h0000_0044);
        rdy = 1'b1;
        step();
        check("str_flush_off", {31'd0, out_flush}, 32'd0);
        wait_ready();

        // reset during RECOVER
        drive(1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0200);
        step();
        idle();
        step();
        check("rr_in_recover", {31'd0, out_commit_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_ready", {31'd0, out_commit_ready}, 32'd1);
        check("rr_flush", {31'd0, out_flush}, 32'd0);
        check("rr_flush_pc", out_flush_pc, 32'd0);
        check("rr_bp_valid", {31'd0, out_bp_valid}, 32'd0);

`ifdef BP_COMMIT_STAT_EN
        // 5 branches, 2nd and 4th mispredicted
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h0000_1000 + 32'(i * 4), 1'b1, (i % 2 == 1) ? 1'b0 : 1'b1, 32'h0);
            step();
            idle();
            wait_ready();
        end
        check("st_branches", out_stat_branches, 32'd5);
        check("st_mispred", out_stat_mispred, 32'd2);
        dut.stat_branches_q = 32'hFFFF_FFFE;
        dut.stat_mispred_q  = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0);
            step();
            idle();
            wait_ready();
        end
        check("st_sat_branches", out_stat_branches, 32'hFFFF_FFFF);
        check("st_sat_mispred", out_stat_mispred, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
